// File: rtl/weight_ram_loader_pkg.sv
// Shared constants for the weight memory loader and the read-side weight ROM
// address controller: FSM state encodings, memory depth, segment base
// addresses and the segment codes reported on the segment output.
package weight_ram_loader_pkg;

  // Total number of weight words and the write-address width.
  localparam int LOAD_DEPTH = 2710;
  localparam int ADDR_W     = 12;

  // First address of each layer segment (CONV1 starts at 0).
  localparam logic [ADDR_W-1:0] SEG_CONV2_BASE = 12'd9;
  localparam logic [ADDR_W-1:0] SEG_CONV3_BASE = 12'd1017;
  localparam logic [ADDR_W-1:0] SEG_FCL1_BASE  = 12'd2025;
  localparam logic [ADDR_W-1:0] SEG_FCL2_BASE  = 12'd2697;
  localparam logic [ADDR_W-1:0] SEG_BIAS_BASE  = 12'd2709;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } load_state_t;

  // Segment codes, shared with the read-side controller's state encoding.
  typedef enum logic [2:0] {
    SEG_CONV1 = 3'b010,
    SEG_CONV2 = 3'b011,
    SEG_CONV3 = 3'b100,
    SEG_FCL1  = 3'b101,
    SEG_FCL2  = 3'b110,
    SEG_BIAS  = 3'b111
  } seg_t;

  // Map a weight-memory address to the layer segment that owns it.
  function automatic seg_t seg_of(input logic [ADDR_W-1:0] addr);
    seg_t seg;
    if (addr < SEG_CONV2_BASE)      seg = SEG_CONV1;
    else if (addr < SEG_CONV3_BASE) seg = SEG_CONV2;
    else if (addr < SEG_FCL1_BASE)  seg = SEG_CONV3;
    else if (addr < SEG_FCL2_BASE)  seg = SEG_FCL1;
    else if (addr < SEG_BIAS_BASE)  seg = SEG_FCL2;
    else                            seg = SEG_BIAS;
    return seg;
  endfunction

endpackage

// File: rtl/COUNTER_LAB.sv
// Codebase up-counter with synchronous clear and count enable.
// Counts 0..MV-1 and holds at MV-1 (terminal count) rather than wrapping.
//   iCLK  : clock
//   iRSTn : asynchronous active-low reset (count -> 0)
//   iCLR  : synchronous clear, has priority over iEN
//   iEN   : count enable
//   oCNT  : current count
//   oTC   : high while the count equals MV-1
module COUNTER_LAB #(
  parameter int WL = 12,
  parameter int MV = 2710
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iCLR,
  input  logic          iEN,
  output logic [WL-1:0] oCNT,
  output logic          oTC
);

  localparam logic [WL-1:0] LAST = WL'(MV - 1);

  assign oTC = (oCNT == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      oCNT <= '0;
    end else if (iCLR) begin
      oCNT <= '0;
    end else if (iEN && !oTC) begin
      oCNT <= oCNT + 1'b1;
    end
  end

endmodule

// File: rtl/weight_ram_loader.sv
// Weight memory loader. Accepts a valid/ready word stream, writes DEPTH words
// to sequential addresses of the weight memory, then takes one checksum word
// and reports whether it matches the mod-2^WL sum of the loaded words.
// Inference must not start until oDONE is high.
//   iCLK, iRSTn : clock, asynchronous active-low reset
//   iSTART      : single-cycle load request (honoured in IDLE, DONE, ERR)
//   iVALID/iDATA: stream word; oREADY high in LOAD and CHECK
//   oWE/oWADDR/oWDATA : registered weight memory write port (1-cycle latency)
//   oSEG        : segment code of the word on the write port
//   oBUSY       : LOAD or CHECK in progress
//   oDONE/oERR  : checksum matched / mismatched, held until the next iSTART
module weight_ram_loader
  import weight_ram_loader_pkg::*;
#(
  parameter int WL    = 8,
  parameter int DEPTH = LOAD_DEPTH
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iSTART,
  input  logic          iVALID,
  input  logic [WL-1:0] iDATA,
  output logic          oREADY,
  output logic          oWE,
  output logic [11:0]   oWADDR,
  output logic [WL-1:0] oWDATA,
  output logic [2:0]    oSEG,
  output logic          oBUSY,
  output logic          oDONE,
  output logic          oERR
);

  load_state_t       state_q, state_d;
  logic              start_acc;
  logic              xfer;
  logic              load_xfer;
  logic              last_load;
  logic [ADDR_W-1:0] addr;
  logic              addr_tc;
  logic [WL-1:0]     sum_q;

  // Handshake and status decode come straight from the state register.
  assign oREADY    = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign oBUSY     = oREADY;
  assign oDONE     = (state_q == ST_DONE);
  assign oERR      = (state_q == ST_ERR);

  assign xfer      = iVALID && oREADY;
  assign load_xfer = xfer && (state_q == ST_LOAD);
  assign last_load = load_xfer && addr_tc;
  // A start is only honoured outside a load; mid-load pulses are ignored.
  assign start_acc = iSTART && ((state_q == ST_IDLE) ||
                                (state_q == ST_DONE) ||
                                (state_q == ST_ERR));

  // Write address counter; cleared on an accepted start, advanced per word.
  COUNTER_LAB #(
    .WL (ADDR_W),
    .MV (DEPTH)
  ) u_addr_cnt (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .iCLR  (start_acc),
    .iEN   (load_xfer),
    .oCNT  (addr),
    .oTC   (addr_tc)
  );

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (start_acc) state_d = ST_LOAD;
      ST_LOAD:                  if (last_load) state_d = ST_CHECK;
      ST_CHECK: begin
        if (xfer) state_d = (iDATA == sum_q) ? ST_DONE : ST_ERR;
      end
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Running checksum of loaded words, wrapping silently at WL bits.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      sum_q <= '0;
    end else if (start_acc) begin
      sum_q <= '0;
    end else if (load_xfer) begin
      sum_q <= sum_q + iDATA;
    end
  end

  // Registered write port. The checksum word (CHECK transfer) never writes.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      oWE    <= 1'b0;
      oWADDR <= '0;
      oWDATA <= '0;
      oSEG   <= SEG_CONV1;
    end else begin
      oWE <= load_xfer;
      if (load_xfer) begin
        oWADDR <= addr;
        oWDATA <= iDATA;
        oSEG   <= seg_of(addr);
      end
    end
  end

endmodule

// File: tb/tb_weight_ram_loader.sv
// Directed bench for weight_ram_loader: nominal load, bad checksum, restart
// from ERR with a mid-load start pulse, backpressured load, reset mid-load.
module tb_weight_ram_loader;

  localparam int N = 2710;

  logic       clk;
  logic       iRSTn, iSTART, iVALID;
  logic [7:0] iDATA;
  logic       oREADY, oWE, oBUSY, oDONE, oERR;
  logic [11:0] oWADDR;
  logic [7:0] oWDATA;
  logic [2:0] oSEG;

  weight_ram_loader #(.WL(8), .DEPTH(N)) dut (
    .iCLK   (clk),
    .iRSTn  (iRSTn),
    .iSTART (iSTART),
    .iVALID (iVALID),
    .iDATA  (iDATA),
    .oREADY (oREADY),
    .oWE    (oWE),
    .oWADDR (oWADDR),
    .oWDATA (oWDATA),
    .oSEG   (oSEG),
    .oBUSY  (oBUSY),
    .oDONE  (oDONE),
    .oERR   (oERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model and write monitor, sampled on the falling edge.
  logic [7:0] mem     [0:4095];
  logic [2:0] seg_log [0:4095];
  int         we_total    = 0;
  int         addr_err    = 0;
  int         over_writes = 0;
  int         both_flags  = 0;
  int         exp_addr    = 0;

  always @(negedge clk) begin
    if (oWE) begin
      mem[oWADDR]     = oWDATA;
      seg_log[oWADDR] = oSEG;
      we_total++;
      if (int'(oWADDR) != exp_addr) addr_err++;
      if (int'(oWADDR) >= N) over_writes++;
      exp_addr = int'(oWADDR) + 1;
    end else if (!oBUSY) begin
      exp_addr = 0;
    end
    if (oDONE && oERR) both_flags++;
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] csum_model;
  int         w0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic start_pulse();
    iSTART = 1'b1;
    @(negedge clk);
    iSTART = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input bit bp, input bit st);
    int waited;
    if (bp && ($urandom_range(0, 1) == 1)) begin
      iVALID = 1'b0;
      @(negedge clk);
    end
    iVALID = 1'b1;
    iDATA  = d;
    iSTART = st;
    waited = 0;
    while (!oREADY && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!oREADY) check("ready_timeout", {31'b0, oREADY}, 32'd1);
    else         @(negedge clk);
    iVALID = 1'b0;
    iSTART = 1'b0;
    iDATA  = 8'hEE;
  endtask

  // Streams words (i[7:0] ^ key); after a full load sends checksum + delta.
  task automatic feed(input bit bp, input logic [7:0] key, input int n_words,
                      input int mid_at, input logic [7:0] delta);
    logic [7:0] d;
    csum_model = 8'h00;
    for (int i = 0; i < n_words; i++) begin
      d = 8'(i) ^ key;
      csum_model = csum_model + d;
      send_word(d, bp, i == mid_at);
    end
    if (n_words == N) send_word(csum_model + delta, bp, 1'b0);
  endtask

  function automatic int mem_bad(input logic [7:0] key);
    int bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== (8'(i) ^ key)) bad++;
    return bad;
  endfunction

  initial begin
    iRSTn  = 1'b0;
    iSTART = 1'b0;
    iVALID = 1'b0;
    iDATA  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_we",     {31'b0, oWE},    32'd0);
    check("rst_waddr",  {20'b0, oWADDR}, 32'd0);
    check("rst_wdata",  {24'b0, oWDATA}, 32'd0);
    check("rst_seg",    {29'b0, oSEG},   32'h2);
    check("rst_busy",   {31'b0, oBUSY},  32'd0);
    check("rst_done",   {31'b0, oDONE},  32'd0);
    check("rst_err",    {31'b0, oERR},   32'd0);
    check("rst_ready",  {31'b0, oREADY}, 32'd0);
    iRSTn = 1'b1;
    @(negedge clk);

    // Stream activity in IDLE is ignored.
    iVALID = 1'b1;
    iDATA  = 8'h5A;
    repeat (3) @(negedge clk);
    check("idle_we",    {31'b0, oWE},    32'd0);
    check("idle_ready", {31'b0, oREADY}, 32'd0);
    check("idle_writes", 32'(we_total), 32'd0);
    iVALID = 1'b0;

    // Nominal load, data = addr[7:0].
    w0 = we_total;
    start_pulse();
    check("nom_busy",  {31'b0, oBUSY},  32'd1);
    check("nom_ready", {31'b0, oREADY}, 32'd1);
    feed(1'b0, 8'h00, N, -1, 8'h00);
    check("nom_csum",   {24'b0, csum_model}, 32'hA7);
    check("nom_done",   {31'b0, oDONE}, 32'd1);
    check("nom_err",    {31'b0, oERR},  32'd0);
    check("nom_busy_end", {31'b0, oBUSY}, 32'd0);
    check("nom_writes", 32'(we_total - w0), 32'd2710);
    check("nom_mem",    32'(mem_bad(8'h00)), 32'd0);
    check("seg_8",    {29'b0, seg_log[8]},    32'h2);
    check("seg_9",    {29'b0, seg_log[9]},    32'h3);
    check("seg_1016", {29'b0, seg_log[1016]}, 32'h3);
    check("seg_1017", {29'b0, seg_log[1017]}, 32'h4);
    check("seg_2024", {29'b0, seg_log[2024]}, 32'h4);
    check("seg_2025", {29'b0, seg_log[2025]}, 32'h5);
    check("seg_2696", {29'b0, seg_log[2696]}, 32'h5);
    check("seg_2697", {29'b0, seg_log[2697]}, 32'h6);
    check("seg_2708", {29'b0, seg_log[2708]}, 32'h6);
    check("seg_2709", {29'b0, seg_log[2709]}, 32'h7);
    repeat (5) @(negedge clk);
    check("done_held", {31'b0, oDONE}, 32'd1);

    // Bad checksum from DONE.
    w0 = we_total;
    start_pulse();
    check("bad_done_clr", {31'b0, oDONE}, 32'd0);
    feed(1'b0, 8'h3C, N, -1, 8'h01);
    check("bad_err",    {31'b0, oERR},  32'd1);
    check("bad_done",   {31'b0, oDONE}, 32'd0);
    check("bad_writes", 32'(we_total - w0), 32'd2710);
    check("bad_over",   32'(over_writes), 32'd0);
    check("bad_mem",    32'(mem_bad(8'h3C)), 32'd0);

    // Restart from ERR, with a start pulse during word 1000.
    w0 = we_total;
    start_pulse();
    check("rs_err_clr", {31'b0, oERR},  32'd0);
    check("rs_busy",    {31'b0, oBUSY}, 32'd1);
    feed(1'b0, 8'hC3, N, 1000, 8'h00);
    check("rs_done",    {31'b0, oDONE}, 32'd1);
    check("rs_writes",  32'(we_total - w0), 32'd2710);
    check("rs_mem",     32'(mem_bad(8'hC3)), 32'd0);

    // Backpressured load, same data as nominal.
    w0 = we_total;
    start_pulse();
    feed(1'b1, 8'h00, N, -1, 8'h00);
    check("bp_done",   {31'b0, oDONE}, 32'd1);
    check("bp_err",    {31'b0, oERR},  32'd0);
    check("bp_writes", 32'(we_total - w0), 32'd2710);
    check("bp_mem",    32'(mem_bad(8'h00)), 32'd0);

    // Reset after 500 writes, then a full reload.
    w0 = we_total;
    start_pulse();
    feed(1'b0, 8'h77, 500, -1, 8'h00);
    #2;
    check("pr_writes", 32'(we_total - w0), 32'd500);
    iRSTn = 1'b0;
    #1;
    check("mr_we",    {31'b0, oWE},    32'd0);
    check("mr_waddr", {20'b0, oWADDR}, 32'd0);
    check("mr_wdata", {24'b0, oWDATA}, 32'd0);
    check("mr_seg",   {29'b0, oSEG},   32'h2);
    check("mr_busy",  {31'b0, oBUSY},  32'd0);
    check("mr_ready", {31'b0, oREADY}, 32'd0);
    check("mr_done",  {31'b0, oDONE},  32'd0);
    check("mr_err",   {31'b0, oERR},   32'd0);
    @(negedge clk);
    iRSTn = 1'b1;
    @(negedge clk);
    w0 = we_total;
    start_pulse();
    feed(1'b0, 8'h11, N, -1, 8'h00);
    check("rl_done",   {31'b0, oDONE}, 32'd1);
    check("rl_writes", 32'(we_total - w0), 32'd2710);
    check("rl_mem",    32'(mem_bad(8'h11)), 32'd0);

    check("addr_sequence", 32'(addr_err),   32'd0);
    check("done_err_excl", 32'(both_flags), 32'd0);
    check("no_over_write", 32'(over_writes), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
